// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end for the pipelined MIPS core.
// Issues single outstanding word reads to instruction memory, buffers the
// returned words in a DEPTH-entry FIFO and presents them on a valid/ready
// interface. Redirects flush the FIFO and discard a stale in-flight fetch.
// Optional feature: define FETCH_OPCODE_CHECK_EN to flag unimplemented
// opcodes on out_illegal (computed at push time, stored per entry).
module fetch_queue #(
  parameter int unsigned         PC_WIDTH = 32,
  parameter int unsigned         DEPTH    = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [5:0]          out_opcode,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic                out_illegal
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic [PC_WIDTH-1:0] tgt_q, tgt_d;
  logic [CW-1:0]       count_q, count_d;
  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic [31:0]         instr_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
  logic                push, pop;
  logic [PC_WIDTH-1:0] redirect_tgt;
  logic                unused_pc_bits;

  assign redirect_tgt   = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];

  assign imem_req   = (state_q != IDLE);
  assign imem_addr  = addr_q;
  assign out_valid  = (count_q != '0);
  assign out_instr  = instr_mem[rd_ptr];
  assign out_pc     = pc_mem[rd_ptr];
  assign out_opcode = out_instr[31:26];

  assign pop  = out_valid && out_ready;
  assign push = (state_q == REQ) && imem_ack && !redirect;

  // Occupancy after this cycle's push/pop; a redirect empties the FIFO.
  always_comb begin
    count_d = count_q;
    if (redirect)
      count_d = '0;
    else
      count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
  end

  // Fetch sequencing: next state, request address and pending redirect target.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    tgt_d   = tgt_q;
    if (redirect) begin
      tgt_d = redirect_tgt;
      case (state_q)
        IDLE: addr_d = redirect_tgt;
        REQ: begin
          if (imem_ack) addr_d = redirect_tgt;
          else          state_d = DISCARD;
        end
        DISCARD: begin
          // The stale access completing this same cycle means nothing is
          // left to discard, so restart straight at the new target.
          if (imem_ack) begin
            state_d = REQ;
            addr_d  = redirect_tgt;
          end
        end
        default: begin
          state_d = IDLE;
          addr_d  = redirect_tgt;
        end
      endcase
    end else begin
      case (state_q)
        IDLE: if (count_d < FULL) state_d = REQ;
        REQ: begin
          if (imem_ack) begin
            addr_d = addr_q + PC_WIDTH'(4);
            if (count_d >= FULL) state_d = IDLE;
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            state_d = REQ;
            addr_d  = tgt_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= RESET_PC;
      tgt_q   <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
      count_q <= count_d;
    end
  end

  // FIFO pointers and storage for instruction word and its address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else begin
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      if (push) begin
        instr_mem[wr_ptr] <= imem_rdata;
        pc_mem[wr_ptr]    <= addr_q;
      end
    end
  end

`ifdef FETCH_OPCODE_CHECK_EN
  logic ill_mem [DEPTH];

  function automatic logic opcode_illegal(input logic [5:0] op);
    case (op)
      6'd0, 6'd2, 6'd4, 6'd8, 6'd35, 6'd43: return 1'b0;
      default:                              return 1'b1;
    endcase
  endfunction

  // Per-entry illegal flag, evaluated once when the word is pushed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) ill_mem[i] <= 1'b0;
    end else if (push) begin
      ill_mem[wr_ptr] <= opcode_illegal(imem_rdata[31:26]);
    end
  end

  assign out_illegal = ill_mem[rd_ptr];
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue: streaming, back-pressure, redirect
// with stale-fetch discard, same-cycle redirect/ack, PC wrap and the
// optional FETCH_OPCODE_CHECK_EN illegal-opcode flag.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [5:0]  out_opcode;
  logic [31:0] out_pc;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  logic        lat_mode;
  int unsigned lat_cnt;
  logic        ill_exp;

  fetch_queue #(
    .PC_WIDTH (32),
    .DEPTH    (2),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_opcode  (out_opcode),
    .out_pc      (out_pc),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  // Memory model: zero-wait acks, or an ack in the third cycle of a request.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  lat_cnt <= 0;
    else if (imem_req && !imem_ack) lat_cnt <= lat_cnt + 1;
    else                           lat_cnt <= 0;
  end

  assign imem_ack   = imem_req && (!lat_mode || lat_cnt == 2);
  assign imem_rdata = (imem_addr == 32'h300) ? 32'h0C00_0000 :
                      (imem_addr == 32'h304) ? 32'h8C00_0000 : imem_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic mode);
    reset_n   = 1'b0;
    redirect  = 1'b0;
    out_ready = 1'b1;
    lat_mode  = mode;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
`ifdef FETCH_OPCODE_CHECK_EN
    ill_exp = 1'b1;
`else
    ill_exp = 1'b0;
`endif
    redirect_pc = 32'h0;
    reset_n     = 1'b0;
    redirect    = 1'b0;
    out_ready   = 1'b1;
    lat_mode    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req",     32'(imem_req),    32'h0);
    check("rst_addr",    imem_addr,        32'h0);
    check("rst_valid",   32'(out_valid),   32'h0);
    check("rst_instr",   out_instr,        32'h0);
    check("rst_opcode",  32'(out_opcode),  32'h0);
    check("rst_pc",      out_pc,           32'h0);
    check("rst_illegal", 32'(out_illegal), 32'h0);

    // Streaming with zero-wait memory.
    do_reset(1'b0);
    cyc();
    check("c1_req",   32'(imem_req),  32'h1);
    check("c1_addr",  imem_addr,      32'h0);
    check("c1_valid", 32'(out_valid), 32'h0);
    cyc();
    check("c2_valid", 32'(out_valid), 32'h1);
    check("c2_pc",    out_pc,         32'h0);
    check("c2_instr", out_instr,      32'h0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check("stream_valid", 32'(out_valid), 32'h1);
      check("stream_pc",    out_pc,         32'(4 * i));
      check("stream_instr", out_instr,      32'(4 * i));
    end

    // Back-pressure: FIFO fills to two entries and fetching stops.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("stall_req",   32'(imem_req),  32'h0);
      check("stall_valid", 32'(out_valid), 32'h1);
      check("stall_pc",    out_pc,         32'h10);
    end
    out_ready = 1'b1;
    cyc();
    check("drain_pc0", out_pc,         32'h14);
    check("drain_req", 32'(imem_req),  32'h1);
    cyc();
    check("drain_pc1", out_pc,         32'h18);
    cyc();
    check("drain_pc2", out_pc,         32'h1C);

    // Redirect while a 3-cycle fetch is outstanding.
    do_reset(1'b1);
    cyc();
    check("lat_issue_addr", imem_addr, 32'h0);
    cyc();
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    check("disc_req",   32'(imem_req),  32'h1);
    check("disc_addr",  imem_addr,      32'h0);
    check("disc_valid", 32'(out_valid), 32'h0);
    cyc();
    check("disc_newaddr", imem_addr,      32'h100);
    check("disc_valid4",  32'(out_valid), 32'h0);
    cyc();
    check("disc_valid5",  32'(out_valid), 32'h0);
    cyc();
    check("disc_valid6",  32'(out_valid), 32'h0);
    cyc();
    check("redir_valid", 32'(out_valid), 32'h1);
    check("redir_pc",    out_pc,         32'h100);
    check("redir_instr", out_instr,      32'h100);

    // Redirect to an unaligned target with an ack in the same cycle.
    do_reset(1'b0);
    cyc();
    cyc();
    cyc();
    check("pre_pc", out_pc, 32'h4);
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    cyc();
    redirect = 1'b0;
    check("sa_valid", 32'(out_valid), 32'h0);
    check("sa_addr",  imem_addr,      32'h200);
    check("sa_req",   32'(imem_req),  32'h1);
    cyc();
    check("sa_pc0",   out_pc,         32'h200);
    check("sa_vld0",  32'(out_valid), 32'h1);
    cyc();
    check("sa_pc1",   out_pc,         32'h204);

    // PC wrap at the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    cyc();
    redirect = 1'b0;
    check("wrap_valid", 32'(out_valid), 32'h0);
    check("wrap_addr",  imem_addr,      32'hFFFF_FFF8);
    cyc();
    check("wrap_pc0", out_pc, 32'hFFFF_FFF8);
    cyc();
    check("wrap_pc1", out_pc, 32'hFFFF_FFFC);
    cyc();
    check("wrap_pc2",    out_pc,    32'h0);
    check("wrap_instr2", out_instr, 32'h0);

    // Opcode legality flag.
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    cyc();
    redirect = 1'b0;
    check("ill_gap", 32'(out_valid), 32'h0);
    cyc();
    check("ill_instr",  out_instr,        32'h0C00_0000);
    check("ill_opcode", 32'(out_opcode),  32'd3);
    check("ill_flag",   32'(out_illegal), 32'(ill_exp));
    cyc();
    check("lw_instr",  out_instr,        32'h8C00_0000);
    check("lw_opcode", 32'(out_opcode),  32'd35);
    check("lw_flag",   32'(out_illegal), 32'h0);
    cyc();
    check("r_instr", out_instr,        32'h308);
    check("r_flag",  32'(out_illegal), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
